// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: instruction-side bus responder for fetch way0.
// Fetch requests read a 64-bit instruction pair from an internal synchronous
// memory. Results travel through a short valid-tagged pipeline into an
// in-order response FIFO. A credit counter limits the requests in flight.
// jumpFlag_i drops every outstanding request.
module inst_fetch_responder #(
  parameter int MemDepthLog2 = 10,
  parameter int Latency      = 2,
  parameter int QueueDepth   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    request_i,
  input  logic [31:0]             addr_i,
  input  logic                    jumpFlag_i,
  output logic                    ready_o,
  output logic                    dataOk_o,
  input  logic                    respReady_i,
  output logic [63:0]             instData_o,
  output logic [31:0]             instAddr_o,
  output logic                    err_o,
  input  logic                    memWe_i,
  input  logic [MemDepthLog2-1:0] memWAddr_i,
  input  logic [63:0]             memWData_i
);

  localparam int MemDepth = 1 << MemDepthLog2;
  localparam int PtrW     = $clog2(QueueDepth);
  localparam int CntW     = $clog2(QueueDepth + 1);

  // Instruction memory, not reset
  logic [63:0] mem_array [MemDepth];

  logic                    flush;
  logic                    accept;
  logic                    pop;
  logic                    fifo_empty;
  logic                    acc_err;
  logic [MemDepthLog2-1:0] acc_idx;

  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] rd_idx;
  logic [PtrW-1:0] wr_idx;

  // FIFO write port, fed by the end of the read pipeline
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_addr;
  logic        fifo_wr_err;
  logic [63:0] fifo_wr_data;

  // FIFO storage; the extra pointer bit tells full from empty
  logic [63:0] fifo_data_q [QueueDepth];
  logic [31:0] fifo_addr_q [QueueDepth];
  logic        fifo_err_q  [QueueDepth];

  assign flush   = jumpFlag_i;
  assign ready_o = (outstanding_q < CntW'(QueueDepth)) && !jumpFlag_i;
  assign accept  = request_i && ready_o;

  // The word index wraps for out-of-range addresses; the error flag zeroes
  // the data later, so the wrapped read does no harm.
  assign acc_idx = addr_i[MemDepthLog2+2:3];
  assign acc_err = (addr_i[2:0] != 3'b000) || (addr_i[31:MemDepthLog2+3] != '0);

  // Memory load port, independent of fetch traffic
  always_ff @(posedge clk) begin
    if (memWe_i) begin
      mem_array[memWAddr_i] <= memWData_i;
    end
  end

  generate
    if (Latency == 1) begin : g_lat1
      // A single cycle leaves no room for a read register, so the FIFO
      // captures the memory word directly on the accept edge.
      assign fifo_wr_en   = accept;
      assign fifo_wr_addr = addr_i;
      assign fifo_wr_err  = acc_err;
      assign fifo_wr_data = acc_err ? 64'd0 : mem_array[acc_idx];
    end else begin : g_pipe
      localparam int NSTG = Latency - 1;

      logic [63:0] rd_data_q;
      logic [63:0] last_data;
      logic        stg_vld_q  [NSTG];
      logic        stg_vld_d  [NSTG];
      logic [31:0] stg_addr_q [NSTG];
      logic [31:0] stg_addr_d [NSTG];
      logic        stg_err_q  [NSTG];
      logic        stg_err_d  [NSTG];

      // Registered read port; a same-edge write to the same word returns the old data
      always_ff @(posedge clk) begin
        if (accept) begin
          rd_data_q <= mem_array[acc_idx];
        end
      end

      // Next state of the valid/address/error shift stages
      always_comb begin
        for (int k = 0; k < NSTG; k++) begin
          stg_vld_d[k]  = 1'b0;
          stg_addr_d[k] = stg_addr_q[k];
          stg_err_d[k]  = stg_err_q[k];
        end
        stg_vld_d[0] = accept;
        if (accept) begin
          stg_addr_d[0] = addr_i;
          stg_err_d[0]  = acc_err;
        end
        for (int k = 1; k < NSTG; k++) begin
          stg_vld_d[k]  = stg_vld_q[k-1] && !flush;
          stg_addr_d[k] = stg_addr_q[k-1];
          stg_err_d[k]  = stg_err_q[k-1];
        end
      end

      // Stage registers
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < NSTG; k++) begin
            stg_vld_q[k]  <= 1'b0;
            stg_addr_q[k] <= 32'd0;
            stg_err_q[k]  <= 1'b0;
          end
        end else begin
          for (int k = 0; k < NSTG; k++) begin
            stg_vld_q[k]  <= stg_vld_d[k];
            stg_addr_q[k] <= stg_addr_d[k];
            stg_err_q[k]  <= stg_err_d[k];
          end
        end
      end

      if (NSTG == 1) begin : g_nodly
        assign last_data = rd_data_q;
      end else begin : g_dly
        logic [63:0] dly_q [NSTG-1];
        // Data follows the valid bits; the read register acts as stage 0
        always_ff @(posedge clk) begin
          dly_q[0] <= rd_data_q;
          for (int k = 1; k < NSTG - 1; k++) begin
            dly_q[k] <= dly_q[k-1];
          end
        end
        assign last_data = dly_q[NSTG-2];
      end

      assign fifo_wr_en   = stg_vld_q[NSTG-1] && !flush;
      assign fifo_wr_addr = stg_addr_q[NSTG-1];
      assign fifo_wr_err  = stg_err_q[NSTG-1];
      assign fifo_wr_data = stg_err_q[NSTG-1] ? 64'd0 : last_data;
    end
  endgenerate

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign rd_idx     = rd_ptr_q[PtrW-1:0];
  assign wr_idx     = wr_ptr_q[PtrW-1:0];
  assign dataOk_o   = !fifo_empty;
  assign pop        = dataOk_o && respReady_i && !flush;

  // Pointer and credit bookkeeping; a flush wins over everything else
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q;
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = '0;
    end else begin
      if (fifo_wr_en) begin
        wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
      end
      case ({accept, pop})
        2'b10:   outstanding_d = outstanding_q + CntW'(1);
        2'b01:   outstanding_d = outstanding_q - CntW'(1);
        default: outstanding_d = outstanding_q;
      endcase
    end
  end

  // Pointer and credit registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
    end
  end

  // FIFO storage write; the credit limit guarantees a free slot
  always_ff @(posedge clk) begin
    if (fifo_wr_en) begin
      fifo_data_q[wr_idx] <= fifo_wr_data;
      fifo_addr_q[wr_idx] <= fifo_wr_addr;
      fifo_err_q[wr_idx]  <= fifo_wr_err;
    end
  end

  // Head outputs read as zero while no response is valid
  always_comb begin
    instData_o = 64'd0;
    instAddr_o = 32'd0;
    err_o      = 1'b0;
    if (dataOk_o) begin
      instData_o = fifo_data_q[rd_idx];
      instAddr_o = fifo_addr_q[rd_idx];
      err_o      = fifo_err_q[rd_idx];
    end
  end

endmodule
